gray_pos_decoder: RTL and testbench
===================================

// Module: gray_pos_decoder
// PURPOSE
//   Receive side of the Gray-coded position interface.
//   - Samples a Gray-coded input (absolute encoder / Gray counter) with a 2-flop synchroniser.
//   - Debounces the sample, converts it to binary and reports single-step moves.
//   - Reports direction and flags illegal multi-bit jumps.
//   - Sits between the external Gray source and position-tracking logic.
// PARAMETERS
//   WIDTH          4   code width in bits (>=2)
//   STABLE_CYCLES  4   consecutive equal samples required before accepting a code (>=1)
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   rst         in   1      synchronous reset, active high
//   gray_in     in   WIDTH  raw Gray code, asynchronous to clk
//   bin         out  WIDTH  binary value of last accepted code
//   locked      out  1      high once an initial code has been accepted
//   step_valid  out  1      1-cycle pulse: accepted code is an adjacent step
//   step_dir    out  1      direction of last step: 1 = up (+1 mod 2^WIDTH), 0 = down; valid with step_valid
//   step_err    out  1      1-cycle pulse: accepted code differs from previous in >1 bit
//   err_cnt     out  8      count of step_err events, saturates at 255
// BEHAVIOUR
//   Reset (rst=1 at an edge)
//   - All outputs, sync flops, candidate and counter go to 0; FSM goes to INIT.
//   - Applies mid-debounce / mid-step; any pending accept is discarded.
//   Sync and debounce
//   - Each edge: s1<=gray_in, s2<=s1.
//   - If s2!=cand: cand<=s2, cnt<=0.
//   - Else if cnt<STABLE_CYCLES-1: cnt++.
//   - Else if cand!=acc_gray: accept; cnt holds.
//   Latency
//   - Accept outputs register STABLE_CYCLES+3 edges after the first edge that samples the new code
//     (7 edges at default).
//   - A code that is not held long enough is never accepted.
//   Conversion
//   - bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
//   - Registered together with acc_gray on accept.
//   FSM INIT
//   - First accept loads acc_gray/bin and sets locked=1.
//   - No step_valid or step_err on this accept; next state TRACK.
//   FSM TRACK, on accept
//   - Let d = popcount(new_gray ^ acc_gray).
//   - d==1: step_valid=1 for one cycle.
//     - step_dir=1 if new_bin == bin+1 mod 2^WIDTH, else 0.
//     - Wrap-around: bin 15->0 is up, 0->15 is down (WIDTH=4).
//   - d>1: step_err=1 for one cycle, err_cnt++ (saturating), step_valid=0.
//     - bin/acc_gray still resync to the new code.
//   - step_dir holds its value between steps.
//   - step_valid and step_err are never high together.
//   Pulses and steady input
//   - step_valid/step_err are 0 on every cycle without an accept.
//   - A held input generates no further pulses.
//   - locked stays 1 until rst.
// TESTING
//   1. rst, then gray_in=0000 held 10 cycles -> locked=1 at edge 7; bin=0; no step_valid/step_err.
//   2. Locked at 0000, gray_in->0001 held -> 7 edges later: step_valid pulse 1 cycle, step_dir=1, bin=1.
//   3. Locked at 1000 (bin 15), gray_in->0000 -> step_dir=1, bin=0.
//      Then ->1000 -> step_dir=0, bin=15.
//   4. Locked at 0000, gray_in=0001 for 2 cycles, then 0000 -> no pulse; bin stays 0.
//   5. Locked at 0000, gray_in->0011 -> step_err pulse, err_cnt=1, bin=2, step_valid=0.
//      Drive 256 jumps -> err_cnt=255.
//   6. rst pulsed 2 cycles after a gray_in change -> all outputs 0, locked=0.
//      Re-lock requires full debounce; no step pulse on re-lock.

Source files
------------

// File: rtl/gray_pos_decoder_if.sv
// Gray-coded position link: raw code from the source, decoded position/step events back.
interface gray_pos_decoder_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin;
    logic             locked;
    logic             step_valid;
    logic             step_dir;
    logic             step_err;
    logic [7:0]       err_cnt;

    // Source side drives the code and observes decoded results.
    modport master (
        output gray_in,
        input  bin,
        input  locked,
        input  step_valid,
        input  step_dir,
        input  step_err,
        input  err_cnt
    );

    // Decoder side.
    modport slave (
        input  gray_in,
        output bin,
        output locked,
        output step_valid,
        output step_dir,
        output step_err,
        output err_cnt
    );
endinterface

// File: rtl/gray_pos_decoder.sv
// Gray position receiver: synchronise, debounce, convert to binary and
// classify each accepted code as an up/down step or an illegal jump.
module gray_pos_decoder #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst,
    gray_pos_decoder_if.slave bus
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned PC_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Synchroniser, with a valid shadow so post-reset flop contents are never debounced.
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic             v1;
    logic             v2;

    logic [WIDTH-1:0] cand;
    logic             cand_valid;
    logic [CNT_W-1:0] cnt;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] acc_gray;
    logic [WIDTH-1:0] acc_gray_nxt;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_nxt;
    logic             locked_q;
    logic             locked_nxt;
    logic             step_valid_q;
    logic             step_valid_nxt;
    logic             step_dir_q;
    logic             step_dir_nxt;
    logic             step_err_q;
    logic             step_err_nxt;
    logic [7:0]       err_cnt_q;
    logic [7:0]       err_cnt_nxt;

    logic             accept_c;
    logic [WIDTH-1:0] cand_bin_c;
    logic [PC_W-1:0]  dist_c;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Sampling and debounce counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            cand       <= '0;
            cand_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            s1 <= bus.gray_in;
            s2 <= s1;
            v1 <= 1'b1;
            v2 <= v1;
            if (v2) begin
                if (!cand_valid || (s2 != cand)) begin
                    cand       <= s2;
                    cand_valid <= 1'b1;
                    cnt        <= '0;
                end else if (cnt != STABLE_LAST) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // A candidate is accepted once it has been stable long enough and is new.
    always_comb begin
        accept_c   = v2 && cand_valid && (s2 == cand) && (cnt == STABLE_LAST)
                     && ((state == ST_INIT) || (cand != acc_gray));
        cand_bin_c = gray2bin(cand);
        dist_c     = popcount(cand ^ acc_gray);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            acc_gray     <= '0;
            bin_q        <= '0;
            locked_q     <= 1'b0;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            step_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state        <= state_nxt;
            acc_gray     <= acc_gray_nxt;
            bin_q        <= bin_nxt;
            locked_q     <= locked_nxt;
            step_valid_q <= step_valid_nxt;
            step_dir_q   <= step_dir_nxt;
            step_err_q   <= step_err_nxt;
            err_cnt_q    <= err_cnt_nxt;
        end
    end

    // Next-state and output logic; pulses default low every cycle.
    always_comb begin
        state_nxt      = state;
        acc_gray_nxt   = acc_gray;
        bin_nxt        = bin_q;
        locked_nxt     = locked_q;
        step_valid_nxt = 1'b0;
        step_dir_nxt   = step_dir_q;
        step_err_nxt   = 1'b0;
        err_cnt_nxt    = err_cnt_q;

        case (state)
            ST_INIT: begin
                if (accept_c) begin
                    acc_gray_nxt = cand;
                    bin_nxt      = cand_bin_c;
                    locked_nxt   = 1'b1;
                    state_nxt    = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept_c) begin
                    acc_gray_nxt = cand;
                    bin_nxt      = cand_bin_c;
                    if (dist_c == PC_W'(1)) begin
                        step_valid_nxt = 1'b1;
                        step_dir_nxt   = (cand_bin_c == WIDTH'(bin_q + WIDTH'(1)));
                    end else begin
                        step_err_nxt = 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_nxt = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign bus.bin        = bin_q;
    assign bus.locked     = locked_q;
    assign bus.step_valid = step_valid_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_pos_decoder.sv
// Directed bench for gray_pos_decoder (WIDTH=4, STABLE_CYCLES=4).
module tb_gray_pos_decoder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    gray_pos_decoder_if #(.WIDTH(4)) bus ();

    gray_pos_decoder #(
        .WIDTH        (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a code and run the six edges before the accept edge, counting stray pulses.
    task automatic move(input logic [3:0] code, output int early);
        bus.gray_in = code;
        early = 0;
        repeat (6) begin
            tick();
            if (bus.step_valid || bus.step_err) early++;
        end
    endtask

    // Apply a single-bit step and check the accept edge and the cycle after it.
    task automatic step(input string tag, input logic [3:0] code,
                        input logic [3:0] exp_bin, input logic exp_dir);
        int early;
        move(code, early);
        check({tag, "_early"}, 32'(early), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.step_valid), 32'd1);
        check({tag, "_err"},   32'(bus.step_err),   32'd0);
        check({tag, "_dir"},   32'(bus.step_dir),   32'(exp_dir));
        check({tag, "_bin"},   32'(bus.bin),        32'(exp_bin));
        tick();
        check({tag, "_pulse_end"}, 32'(bus.step_valid), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        int early;
        int quiet;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.gray_in = 4'b0000;
        repeat (2) tick();
        check("rst_bin",    32'(bus.bin),        32'd0);
        check("rst_locked", 32'(bus.locked),     32'd0);
        check("rst_valid",  32'(bus.step_valid), 32'd0);
        check("rst_err",    32'(bus.step_err),   32'd0);
        check("rst_errcnt", 32'(bus.err_cnt),    32'd0);
        rst = 1'b0;

        // Initial lock at edge 7 after reset release.
        repeat (6) tick();
        check("init_locked_e6", 32'(bus.locked), 32'd0);
        tick();
        check("init_locked_e7", 32'(bus.locked),     32'd1);
        check("init_bin",       32'(bus.bin),        32'd0);
        check("init_valid",     32'(bus.step_valid), 32'd0);
        check("init_err",       32'(bus.step_err),   32'd0);
        quiet = 0;
        repeat (3) begin
            tick();
            if (bus.step_valid || bus.step_err) quiet++;
        end
        check("init_hold_quiet", 32'(quiet), 32'd0);

        // Single steps, including wrap-around both ways.
        step("up_0_1",    4'b0001, 4'd1,  1'b1);
        step("dn_1_0",    4'b0000, 4'd0,  1'b0);
        step("dn_0_15",   4'b1000, 4'd15, 1'b0);
        step("up_15_0",   4'b0000, 4'd0,  1'b1);
        step("dn_0_15b",  4'b1000, 4'd15, 1'b0);
        step("up_15_0b",  4'b0000, 4'd0,  1'b1);

        // Glitch shorter than the debounce window.
        bus.gray_in = 4'b0001;
        repeat (2) tick();
        bus.gray_in = 4'b0000;
        quiet = 0;
        repeat (12) begin
            tick();
            if (bus.step_valid || bus.step_err) quiet++;
        end
        check("glitch_quiet", 32'(quiet),   32'd0);
        check("glitch_bin",   32'(bus.bin), 32'd0);

        // Illegal two-bit jump 0000 -> 0011 (bin 2).
        move(4'b0011, early);
        check("jump_early", 32'(early), 32'd0);
        tick();
        check("jump_err",    32'(bus.step_err),   32'd1);
        check("jump_valid",  32'(bus.step_valid), 32'd0);
        check("jump_errcnt", 32'(bus.err_cnt),    32'd1);
        check("jump_bin",    32'(bus.bin),        32'd2);
        check("jump_dir",    32'(bus.step_dir),   32'd1);
        tick();
        check("jump_pulse_end", 32'(bus.step_err), 32'd0);

        // 255 more jumps alternating 0000/0011; counter must saturate at 255.
        for (int i = 1; i <= 255; i++) begin
            move((i % 2 == 1) ? 4'b0000 : 4'b0011, early);
            tick();
            tick();
            if (i == 253) check("sat_254", 32'(bus.err_cnt), 32'd254);
            if (i == 254) check("sat_255", 32'(bus.err_cnt), 32'd255);
        end
        check("sat_hold",     32'(bus.err_cnt), 32'd255);
        check("sat_last_bin", 32'(bus.bin),     32'd0);

        // Reset two cycles into a pending change, then re-lock on the held code.
        bus.gray_in = 4'b0001;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst2_bin",    32'(bus.bin),      32'd0);
        check("rst2_locked", 32'(bus.locked),   32'd0);
        check("rst2_errcnt", 32'(bus.err_cnt),  32'd0);
        check("rst2_dir",    32'(bus.step_dir), 32'd0);
        rst = 1'b0;
        quiet = 0;
        repeat (6) begin
            tick();
            if (bus.step_valid || bus.step_err) quiet++;
        end
        check("relock_e6", 32'(bus.locked), 32'd0);
        tick();
        check("relock_e7",    32'(bus.locked),     32'd1);
        check("relock_bin",   32'(bus.bin),        32'd1);
        check("relock_valid", 32'(bus.step_valid), 32'd0);
        check("relock_err",   32'(bus.step_err),   32'd0);
        check("relock_quiet", 32'(quiet),          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
